// File: rtl/moving_avg_filter_param.sv
// rtl/moving_avg_filter_param.sv - runtime-windowed moving-average filter with fill phase
module moving_avg_filter_param #(
    parameter int BW           = 16,
    parameter int LOG2_MAX_LEN = 4,
    parameter int ROUND        = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [$clog2(LOG2_MAX_LEN+1)-1:0]   len_sel_i,
    input  logic                                flush_i,
    input  logic                                valid_i,
    input  logic [BW-1:0]                       filter_i,
    output logic                                valid_o,
    output logic [BW-1:0]                       filter_o,
    output logic                                filled_o
);

    localparam int KW = $clog2(LOG2_MAX_LEN+1);
    localparam int PW = LOG2_MAX_LEN;
    localparam int N  = 1 << PW;
    localparam int AW = BW + PW;
    localparam int CW = PW + 1;

    typedef enum logic {FILL, RUN} state_t;

    state_t                 state_q, state_n;
    logic [KW-1:0]          k_q, k_n, k_req;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          fill_cnt, fill_n;
    logic [CW-1:0]          l_full, last_cnt;
    logic signed [AW-1:0]   acc_q, acc_n;
    logic signed [AW-1:0]   x_ext, old_ext, rnd_off, sum_r;
    logic [BW-1:0]          filter_n;
    logic [BW-1:0]          filter_q;
    logic                   valid_q;
    logic                   emit;
    logic                   wr_en;
    logic [BW-1:0]          mem [N];

    assign k_req    = (len_sel_i > KW'(LOG2_MAX_LEN)) ? KW'(LOG2_MAX_LEN) : len_sel_i;
    assign l_full   = CW'(1) << k_q;
    assign last_cnt = l_full - CW'(1);
    // For L == N the truncated length is zero, so the oldest word is the slot about to be overwritten.
    assign rd_ptr   = wr_ptr - PW'(l_full);
    assign x_ext    = {{PW{filter_i[BW-1]}}, filter_i};
    assign old_ext  = {{PW{mem[rd_ptr][BW-1]}}, mem[rd_ptr]};

    always_comb begin
        state_n = state_q;
        k_n     = k_q;
        acc_n   = acc_q;
        fill_n  = fill_cnt;
        emit    = 1'b0;
        wr_en   = 1'b0;
        if (flush_i) begin
            k_n     = k_req;
            acc_n   = '0;
            fill_n  = '0;
            state_n = FILL;
        end else if (k_req != k_q) begin
            k_n     = k_req;
            state_n = FILL;
            if (valid_i) begin
                wr_en  = 1'b1;
                acc_n  = x_ext;
                fill_n = CW'(1);
                if (k_req == '0) begin
                    state_n = RUN;
                    emit    = 1'b1;
                end
            end else begin
                acc_n  = '0;
                fill_n = '0;
            end
        end else if (valid_i) begin
            wr_en = 1'b1;
            case (state_q)
                FILL: begin
                    acc_n = acc_q + x_ext;
                    if (fill_cnt == last_cnt) begin
                        state_n = RUN;
                        emit    = 1'b1;
                    end else begin
                        fill_n = fill_cnt + CW'(1);
                    end
                end
                RUN: begin
                    acc_n = acc_q + x_ext - old_ext;
                    emit  = 1'b1;
                end
                default: state_n = FILL;
            endcase
        end
    end

    // Output scaling uses the window the emitted sample belongs to.
    always_comb begin
        rnd_off = '0;
        if (ROUND != 0 && k_n != '0)
            rnd_off = AW'(1) << (k_n - KW'(1));
        sum_r    = acc_n + rnd_off;
        filter_n = BW'(sum_r >>> k_n);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= FILL;
            k_q      <= k_req;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            acc_q    <= '0;
            valid_q  <= 1'b0;
            filter_q <= '0;
        end else begin
            state_q  <= state_n;
            k_q      <= k_n;
            acc_q    <= acc_n;
            fill_cnt <= fill_n;
            valid_q  <= emit;
            if (emit)
                filter_q <= filter_n;
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en)
            mem[wr_ptr] <= filter_i;
    end

    assign valid_o  = valid_q;
    assign filter_o = filter_q;
    assign filled_o = (state_q == RUN);

endmodule

// File: tb/tb_moving_avg_filter_param.sv
// tb/tb_moving_avg_filter_param.sv - self-checking bench for moving_avg_filter_param
module tb_moving_avg_filter_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        vin = 1'b0;
    logic [2:0]  len_sel = 3'd0;
    logic [15:0] xin = 16'd0;
    logic        v0, v1, fl0, fl1;
    logic [15:0] f0, f1;

    int checks = 0;
    int failures = 0;

    int          win[$];
    int          m_k = 0;
    bit          m_run = 1'b0;
    bit          m_v = 1'b0;
    bit          m_f = 1'b0;
    logic [15:0] m_o0 = 16'd0;
    logic [15:0] m_o1 = 16'd0;

    moving_avg_filter_param #(.BW(16), .LOG2_MAX_LEN(4), .ROUND(0)) dut_trunc (
        .clk_i(clk), .rst_i(rst), .len_sel_i(len_sel), .flush_i(flush),
        .valid_i(vin), .filter_i(xin), .valid_o(v0), .filter_o(f0), .filled_o(fl0)
    );

    moving_avg_filter_param #(.BW(16), .LOG2_MAX_LEN(4), .ROUND(1)) dut_round (
        .clk_i(clk), .rst_i(rst), .len_sel_i(len_sel), .flush_i(flush),
        .valid_i(vin), .filter_i(xin), .valid_o(v1), .filter_o(f1), .filled_o(fl1)
    );

    always #5 clk = ~clk;

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0))
            q = q - 1;
        return q;
    endfunction

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    // Reference: the window is the list of samples accepted since the last restart;
    // the output is the floor (or round-half-up) mean of its newest L entries.
    task automatic step(input bit r, input bit f, input int len, input bit v, input int x);
        int kr, ln, s;
        rst = r; flush = f; len_sel = 3'(len); vin = v; xin = 16'(x);
        @(posedge clk);
        #1;
        kr  = (len > 4) ? 4 : len;
        m_v = 1'b0;
        if (r) begin
            win.delete(); m_k = kr; m_run = 1'b0; m_o0 = 16'd0; m_o1 = 16'd0;
        end else if (f) begin
            win.delete(); m_k = kr; m_run = 1'b0;
        end else begin
            if (kr != m_k) begin
                m_k = kr; win.delete(); m_run = 1'b0;
            end
            if (v) begin
                win.push_back(x);
                ln = 1 << m_k;
                if (win.size() >= ln) begin
                    s = 0;
                    for (int i = 0; i < ln; i++)
                        s += win[win.size() - 1 - i];
                    m_o0  = 16'(fdiv(s, ln));
                    m_o1  = 16'(fdiv(s + ln / 2, ln));
                    m_v   = 1'b1;
                    m_run = 1'b1;
                end
                while (win.size() > 16)
                    void'(win.pop_front());
            end
        end
        m_f = m_run;
        rst = 1'b0; flush = 1'b0; vin = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 3, (i == 1), 1234);
            checks += 4;
            if (v0 !== 1'b0 || v1 !== 1'b0) begin failures++; $display("FAIL reset valid_o got %b/%b expected 0", v0, v1); end
            if (f0 !== 16'd0 || f1 !== 16'd0) begin failures++; $display("FAIL reset filter_o got %0d/%0d expected 0", $signed(f0), $signed(f1)); end
            if (fl0 !== 1'b0 || fl1 !== 1'b0) begin failures++; $display("FAIL reset filled_o got %b/%b expected 0", fl0, fl1); end
            if (f0 !== m_o0) begin failures++; $display("FAIL reset model filter_o got %0d expected %0d", $signed(f0), $signed(m_o0)); end
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 3, 1, 100);
            checks += 4;
            if (v0 !== m_v || v1 !== m_v) begin failures++; $display("FAIL fill[%0d] valid_o got %b/%b expected %b", i, v0, v1, m_v); end
            if (f0 !== m_o0) begin failures++; $display("FAIL fill[%0d] filter_o trunc got %0d expected %0d", i, $signed(f0), $signed(m_o0)); end
            if (f1 !== m_o1) begin failures++; $display("FAIL fill[%0d] filter_o round got %0d expected %0d", i, $signed(f1), $signed(m_o1)); end
            if (fl0 !== m_f || fl1 !== m_f) begin failures++; $display("FAIL fill[%0d] filled_o got %b/%b expected %b", i, fl0, fl1, m_f); end
        end
        checks++;
        if (f0 !== 16'd100 || fl0 !== 1'b1) begin failures++; $display("FAIL fill_final filter_o/filled_o got %0d/%b expected 100/1", $signed(f0), fl0); end
    endtask

    task automatic test_step_gaps();
        int n;
        bit v;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            v = (i < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(0, 0, 3, v, (i < 8) ? 0 : 800);
            checks += 4;
            if (v0 !== m_v || v1 !== m_v) begin failures++; $display("FAIL step[%0d] valid_o got %b/%b expected %b", i, v0, v1, m_v); end
            if (f0 !== m_o0) begin failures++; $display("FAIL step[%0d] filter_o trunc got %0d expected %0d", i, $signed(f0), $signed(m_o0)); end
            if (f1 !== m_o1) begin failures++; $display("FAIL step[%0d] filter_o round got %0d expected %0d", i, $signed(f1), $signed(m_o1)); end
            if (fl0 !== m_f || fl1 !== m_f) begin failures++; $display("FAIL step[%0d] filled_o got %b/%b expected %b", i, fl0, fl1, m_f); end
            if (i >= 8 && v && n < 8) begin
                n++;
                checks++;
                if (f0 !== 16'(100 * n)) begin failures++; $display("FAIL step_ramp[%0d] filter_o got %0d expected %0d", n, $signed(f0), 100 * n); end
            end
        end
    endtask

    task automatic test_round();
        int smp[5] = '{0, -1, -1, -1, -2};
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 2, (i != 0), smp[i]);
            checks += 4;
            if (v0 !== m_v || v1 !== m_v) begin failures++; $display("FAIL round[%0d] valid_o got %b/%b expected %b", i, v0, v1, m_v); end
            if (f0 !== m_o0) begin failures++; $display("FAIL round[%0d] filter_o trunc got %0d expected %0d", i, $signed(f0), $signed(m_o0)); end
            if (f1 !== m_o1) begin failures++; $display("FAIL round[%0d] filter_o round got %0d expected %0d", i, $signed(f1), $signed(m_o1)); end
            if (fl0 !== m_f || fl1 !== m_f) begin failures++; $display("FAIL round[%0d] filled_o got %b/%b expected %b", i, fl0, fl1, m_f); end
        end
        checks++;
        if (f0 !== 16'hFFFE || f1 !== 16'hFFFF) begin failures++; $display("FAIL round_sum-5 filter_o got %0d/%0d expected -2/-1", $signed(f0), $signed(f1)); end
    endtask

    task automatic test_wrap();
        step(0, 0, 4, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 4, 1, i);
            checks += 4;
            if (v0 !== m_v || v1 !== m_v) begin failures++; $display("FAIL wrap[%0d] valid_o got %b/%b expected %b", i, v0, v1, m_v); end
            if (f0 !== m_o0) begin failures++; $display("FAIL wrap[%0d] filter_o trunc got %0d expected %0d", i, $signed(f0), $signed(m_o0)); end
            if (f1 !== m_o1) begin failures++; $display("FAIL wrap[%0d] filter_o round got %0d expected %0d", i, $signed(f1), $signed(m_o1)); end
            if (fl0 !== m_f || fl1 !== m_f) begin failures++; $display("FAIL wrap[%0d] filled_o got %b/%b expected %b", i, fl0, fl1, m_f); end
        end
        checks++;
        if (f0 !== 16'd31) begin failures++; $display("FAIL wrap_last filter_o got %0d expected 31", $signed(f0)); end
    endtask

    task automatic test_window_change();
        int len, v, x;
        for (int i = 0; i < 22; i++) begin
            len = (i < 9) ? 3 : (i < 11) ? 1 : 0;
            v   = (i != 0);
            x   = (i == 9) ? 40 : (i == 10) ? 20 : rnd16();
            step(0, 0, len, v, x);
            checks += 4;
            if (v0 !== m_v || v1 !== m_v) begin failures++; $display("FAIL winchg[%0d] valid_o got %b/%b expected %b", i, v0, v1, m_v); end
            if (f0 !== m_o0) begin failures++; $display("FAIL winchg[%0d] filter_o trunc got %0d expected %0d", i, $signed(f0), $signed(m_o0)); end
            if (f1 !== m_o1) begin failures++; $display("FAIL winchg[%0d] filter_o round got %0d expected %0d", i, $signed(f1), $signed(m_o1)); end
            if (fl0 !== m_f || fl1 !== m_f) begin failures++; $display("FAIL winchg[%0d] filled_o got %b/%b expected %b", i, fl0, fl1, m_f); end
            if (i == 10) begin
                checks++;
                if (f0 !== 16'd30 || v0 !== 1'b1) begin failures++; $display("FAIL winchg_l2 filter_o got %0d valid %b expected 30/1", $signed(f0), v0); end
            end
            if (i >= 11) begin
                checks++;
                if (f0 !== 16'(x) || f1 !== 16'(x)) begin failures++; $display("FAIL passthru[%0d] filter_o got %0d/%0d expected %0d", i, $signed(f0), $signed(f1), x); end
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 11; i++) begin
            if (i == 5)
                step(0, 1, 2, 1, 555);
            else
                step(0, 0, 2, (i != 0), rnd16());
            checks += 4;
            if (v0 !== m_v || v1 !== m_v) begin failures++; $display("FAIL flush[%0d] valid_o got %b/%b expected %b", i, v0, v1, m_v); end
            if (f0 !== m_o0) begin failures++; $display("FAIL flush[%0d] filter_o trunc got %0d expected %0d", i, $signed(f0), $signed(m_o0)); end
            if (f1 !== m_o1) begin failures++; $display("FAIL flush[%0d] filter_o round got %0d expected %0d", i, $signed(f1), $signed(m_o1)); end
            if (fl0 !== m_f || fl1 !== m_f) begin failures++; $display("FAIL flush[%0d] filled_o got %b/%b expected %b", i, fl0, fl1, m_f); end
            if (i == 5) begin
                checks++;
                if (v0 !== 1'b0 || fl0 !== 1'b0) begin failures++; $display("FAIL flush_drop valid_o/filled_o got %b/%b expected 0/0", v0, fl0); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            step((i == 2), 0, 3, 1, rnd16());
            checks += 4;
            if (v0 !== m_v || v1 !== m_v) begin failures++; $display("FAIL rstmid[%0d] valid_o got %b/%b expected %b", i, v0, v1, m_v); end
            if (f0 !== m_o0) begin failures++; $display("FAIL rstmid[%0d] filter_o trunc got %0d expected %0d", i, $signed(f0), $signed(m_o0)); end
            if (f1 !== m_o1) begin failures++; $display("FAIL rstmid[%0d] filter_o round got %0d expected %0d", i, $signed(f1), $signed(m_o1)); end
            if (fl0 !== m_f || fl1 !== m_f) begin failures++; $display("FAIL rstmid[%0d] filled_o got %b/%b expected %b", i, fl0, fl1, m_f); end
            if (i == 2) begin
                checks++;
                if (v0 !== 1'b0 || f0 !== 16'd0 || fl0 !== 1'b0) begin failures++; $display("FAIL rstmid_zero got v=%b f=%0d filled=%b expected 0/0/0", v0, $signed(f0), fl0); end
            end
        end
    endtask

    task automatic test_random();
        int len;
        len = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 4)
                len = $urandom_range(0, 7);
            step(0, ($urandom_range(0, 99) < 2), len, ($urandom_range(0, 99) < 75), rnd16());
            checks += 4;
            if (v0 !== m_v || v1 !== m_v) begin failures++; $display("FAIL rand[%0d] valid_o got %b/%b expected %b", i, v0, v1, m_v); end
            if (f0 !== m_o0) begin failures++; $display("FAIL rand[%0d] filter_o trunc got %0d expected %0d", i, $signed(f0), $signed(m_o0)); end
            if (f1 !== m_o1) begin failures++; $display("FAIL rand[%0d] filter_o round got %0d expected %0d", i, $signed(f1), $signed(m_o1)); end
            if (fl0 !== m_f || fl1 !== m_f) begin failures++; $display("FAIL rand[%0d] filled_o got %b/%b expected %b", i, fl0, fl1, m_f); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_step_gaps();
        test_round();
        test_wrap();
        test_window_change();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
